// File: rtl/fp_mul.sv
// fp_mul: 3-stage pipelined binary32 multiplier, round-to-nearest-even,
// subnormal inputs read as zero, tiny results flushed to zero, flags {invalid, overflow, underflow}.
module fp_mul (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        aclken,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] result_out,
    output logic        result_tvalid,
    output logic [2:0]  result_tuser
);
    typedef enum logic [1:0] {K_ZERO, K_NORM, K_INF, K_NAN} kind_t;

    logic [2:0]        vld_q, vld_d;
    kind_t             s1_kind_q, s1_kind_d, s2_kind_q, s2_kind_d;
    logic              s1_sign_q, s1_sign_d, s2_sign_q, s2_sign_d;
    logic signed [9:0] s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
    logic [47:0]       s1_prod_q, s1_prod_d;
    logic [22:0]       s2_frac_q, s2_frac_d;
    logic [31:0]       res_q, res_d;
    logic [2:0]        flags_q, flags_d;

    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0]       ma, mb, mant;
    logic              guard, sticky;
    logic [24:0]       rnd;
    logic signed [9:0] exp_n;

    always_comb begin
        a_zero    = a_in[30:23] == 8'h00;
        b_zero    = b_in[30:23] == 8'h00;
        a_inf     = (&a_in[30:23]) && a_in[22:0] == 23'd0;
        b_inf     = (&b_in[30:23]) && b_in[22:0] == 23'd0;
        a_nan     = (&a_in[30:23]) && (|a_in[22:0]);
        b_nan     = (&b_in[30:23]) && (|b_in[22:0]);
        s1_kind_d = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? K_NAN :
                    (a_inf || b_inf) ? K_INF :
                    (a_zero || b_zero) ? K_ZERO : K_NORM;
        s1_sign_d = a_in[31] ^ b_in[31];
        s1_exp_d  = $signed({2'b00, a_in[30:23]}) + $signed({2'b00, b_in[30:23]}) - 10'sd127;
        ma        = {1'b1, a_in[22:0]};
        mb        = {1'b1, b_in[22:0]};
        s1_prod_d = 48'(ma) * 48'(mb);
    end

    // Product of two 1.x mantissas lies in [1,4): bit 47 decides the one-place normalise.
    always_comb begin
        mant      = s1_prod_q[47] ? s1_prod_q[47:24] : s1_prod_q[46:23];
        guard     = s1_prod_q[47] ? s1_prod_q[23] : s1_prod_q[22];
        sticky    = s1_prod_q[47] ? |s1_prod_q[22:0] : |s1_prod_q[21:0];
        exp_n     = s1_exp_q + (s1_prod_q[47] ? 10'sd1 : 10'sd0);
        rnd       = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
        s2_frac_d = rnd[24] ? rnd[23:1] : rnd[22:0];
        s2_exp_d  = exp_n + (rnd[24] ? 10'sd1 : 10'sd0);
        s2_sign_d = s1_sign_q;
        s2_kind_d = s1_kind_q;
    end

    always_comb begin
        res_d   = {s2_sign_q, 31'd0};
        flags_d = 3'b000;
        if (s2_kind_q == K_NAN) begin
            res_d   = 32'h7FC0_0000;
            flags_d = 3'b100;
        end else if (s2_kind_q == K_INF) begin
            res_d = {s2_sign_q, 8'hFF, 23'd0};
        end else if (s2_kind_q == K_NORM) begin
            if (s2_exp_q >= 10'sd255) begin
                res_d   = {s2_sign_q, 8'hFF, 23'd0};
                flags_d = 3'b010;
            end else if (s2_exp_q <= 10'sd0) begin
                flags_d = 3'b001;
            end else begin
                res_d = {s2_sign_q, s2_exp_q[7:0], s2_frac_q};
            end
        end
        vld_d = {vld_q[1:0], 1'b1};
    end

    // Reset leaves stage 2 holding a zero, so the output stays 0 until real data arrives.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q     <= 3'b000;
            s1_kind_q <= K_ZERO;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= 10'sd0;
            s1_prod_q <= 48'd0;
            s2_kind_q <= K_ZERO;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= 10'sd0;
            s2_frac_q <= 23'd0;
            res_q     <= 32'd0;
            flags_q   <= 3'b000;
        end else if (aclken) begin
            vld_q     <= vld_d;
            s1_kind_q <= s1_kind_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_prod_q <= s1_prod_d;
            s2_kind_q <= s2_kind_d;
            s2_sign_q <= s2_sign_d;
            s2_exp_q  <= s2_exp_d;
            s2_frac_q <= s2_frac_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
        end
    end

    assign result_out    = res_q;
    assign result_tvalid = vld_q[2];
    assign result_tuser  = flags_q;
endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: directed vectors streamed back-to-back through fp_mul, with a clock-enable
// stall in the first pass and an asynchronous reset while results are in flight.
module tb_fp_mul;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        aclken = 1'b0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic [31:0] result_out;
    logic        result_tvalid;
    logic [2:0]  result_tuser;
    int          errors = 0;
    int          checks = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;
    vec_t vecs[$];

    fp_mul dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .aclken(aclken),
        .a_in(a_in),
        .b_in(b_in),
        .result_out(result_out),
        .result_tvalid(result_tvalid),
        .result_tuser(result_tuser)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic [2:0] f);
        vec_t v;
        v.a = a;
        v.b = b;
        v.r = r;
        v.f = f;
        vecs.push_back(v);
    endtask

    // n counts enabled edges; the output after n edges belongs to vector n-3.
    task automatic stream(input int stall_at);
        int n = 0;
        int cyc = 0;
        while (1) begin
            @(negedge aclk);
            if (aclken) n++;
            if (n >= 3) begin
                check($sformatf("result[%0d]", n - 3), result_out, vecs[n - 3].r);
                check($sformatf("tuser[%0d]", n - 3), 32'(result_tuser), 32'(vecs[n - 3].f));
                check($sformatf("tvalid[%0d]", n - 3), 32'(result_tvalid), 32'd1);
            end else begin
                check($sformatf("tvalid_fill%0d", n), 32'(result_tvalid), 32'd0);
                check($sformatf("result_fill%0d", n), result_out, 32'd0);
            end
            if (n == vecs.size() + 2) break;
            aclken = (cyc < stall_at || cyc >= stall_at + 4);
            if (aclken && n < vecs.size()) begin
                a_in = vecs[n].a;
                b_in = vecs[n].b;
            end else begin
                a_in = 32'h7FFF_FFFF;
                b_in = 32'h7FFF_FFFF;
            end
            cyc++;
        end
        aclken = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        add(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 3'b000);
        add(32'h4040_0000, 32'h4080_0000, 32'h4140_0000, 3'b000);
        add(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000);
        add(32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000, 3'b000);
        add(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b010);
        add(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100);
        add(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b001);
        add(32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b100);
        add(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b100);
        add(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000);
        add(32'hFF80_0000, 32'hFF80_0000, 32'h7F80_0000, 3'b000);
        add(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3'b000);
        add(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 3'b000);
        add(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000);
        add(32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 3'b000);
        add(32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 3'b000);
        add(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 3'b010);
        add(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 3'b000);
        add(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 3'b000);

        #12;
        check("reset_result", result_out, 32'd0);
        check("reset_tvalid", 32'(result_tvalid), 32'd0);
        check("reset_tuser", 32'(result_tuser), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        stream(6);

        aclken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in = vecs[i].a;
            b_in = vecs[i].b;
            @(negedge aclk);
        end
        check("pre_reset_result", result_out, vecs[1].r);
        check("pre_reset_tvalid", 32'(result_tvalid), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("mid_reset_result", result_out, 32'd0);
        check("mid_reset_tvalid", 32'(result_tvalid), 32'd0);
        check("mid_reset_tuser", 32'(result_tuser), 32'd0);
        aclken = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        stream(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
